// File: rtl/uart_line_echo.sv
// Line echo between two Avalon-ST byte streams: buffers received bytes, then replays the line.
// Latency: first byte valid on the cycle after the FILL->DRAIN edge; one byte per accepted beat.
// Backpressure: input ready only in FILL with room; output holds data until to_uart_ready.
// Optional macro UART_CASE_FLIP_EN: map lowercase a..z to uppercase on the way out.
module uart_line_echo #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] from_uart_data,
  input  logic       from_uart_valid,
  input  logic       from_uart_error,
  output logic       from_uart_ready,
  output logic [7:0] to_uart_data,
  output logic       to_uart_valid,
  output logic       to_uart_error,
  input  logic       to_uart_ready,
  output logic [7:0] err_count,
  output logic [7:0] line_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_LVL = CW'(DEPTH - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, err_beat;
  logic [7:0]    head_byte, out_byte;

  // State register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= FILL;
    else                state <= state_nxt;
  end

  // Next state and handshakes; an error beat is accepted but never stored or counted as a terminator.
  always_comb begin
    state_nxt       = state;
    from_uart_ready = 1'b0;
    to_uart_valid   = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    err_beat        = 1'b0;
    case (state)
      FILL: begin
        from_uart_ready = reset_reset_n && (count < FULL_LVL);
        push     = from_uart_valid && from_uart_ready && !from_uart_error;
        err_beat = from_uart_valid && from_uart_ready && from_uart_error;
        if (push && ((from_uart_data == TERM_CHAR) || (count == LAST_LVL)))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        to_uart_valid = reset_reset_n;
        pop           = to_uart_valid && to_uart_ready;
        if (pop && (count == CW'(1)))
          state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Byte storage; contents are don't-care after reset since count gates every read.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= from_uart_data;
  end

  // Pointers, occupancy and the two statistics counters.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_count  <= 8'd0;
      line_count <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
        if (count == CW'(1)) line_count <= line_count + 8'd1;
      end
      if (err_beat && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  assign head_byte = mem[rd_ptr];

`ifdef UART_CASE_FLIP_EN
  assign out_byte = ((head_byte >= 8'h61) && (head_byte <= 8'h7A)) ? (head_byte - 8'h20) : head_byte;
`else
  assign out_byte = head_byte;
`endif

  // Data is forced to zero whenever nothing is being offered, including reset.
  assign to_uart_data  = to_uart_valid ? out_byte : 8'h00;
  assign to_uart_error = 1'b0;

endmodule

// File: tb/tb_uart_line_echo.sv
// Self-checking bench for uart_line_echo: scoreboard of expected echo bytes.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Mirrors UART_CASE_FLIP_EN so the expected bytes follow the build.
module tb_uart_line_echo;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] from_uart_data;
  logic       from_uart_valid;
  logic       from_uart_error;
  logic       from_uart_ready;
  logic [7:0] to_uart_data;
  logic       to_uart_valid;
  logic       to_uart_error;
  logic       to_uart_ready;
  logic [7:0] err_count;
  logic [7:0] line_count;

  int         tests = 0;
  int         fails = 0;
  int         out_cnt = 0;
  logic [7:0] exp_q[$];
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h00;

  uart_line_echo #(.DEPTH(16), .TERM_CHAR(8'h0D)) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .from_uart_data  (from_uart_data),
    .from_uart_valid (from_uart_valid),
    .from_uart_error (from_uart_error),
    .from_uart_ready (from_uart_ready),
    .to_uart_data    (to_uart_data),
    .to_uart_valid   (to_uart_valid),
    .to_uart_error   (to_uart_error),
    .to_uart_ready   (to_uart_ready),
    .err_count       (err_count),
    .line_count      (line_count)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_out(input logic [7:0] b);
`ifdef UART_CASE_FLIP_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance; returns at edge+1 after the transfer edge.
  task automatic send_byte(input logic [7:0] d, input logic e);
    int n = 0;
    from_uart_data  = d;
    from_uart_error = e;
    from_uart_valid = 1'b1;
    @(negedge clk_clk);
    while (!from_uart_ready && n < 200) begin
      @(negedge clk_clk);
      n++;
    end
    if (!from_uart_ready) check("send_timeout", 0, 1);
    else if (!e) exp_q.push_back(exp_out(d));
    step();
    from_uart_valid = 1'b0;
    from_uart_error = 1'b0;
  endtask

  // Wait (bounded) until every expected byte has come out and the block is idle.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk_clk);
    while ((exp_q.size() != 0 || to_uart_valid) && n < 500) begin
      @(negedge clk_clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 0, 1);
    step();
  endtask

  // Output monitor: scoreboard compare on each transfer, hold check across stalls.
  always @(negedge clk_clk) begin
    if (stalled) begin
      check("stall_vld", 32'(to_uart_valid), 1);
      check("stall_dat", 32'(to_uart_data), 32'(held));
    end
    stalled = to_uart_valid && !to_uart_ready;
    held    = to_uart_data;
    if (to_uart_valid && to_uart_ready) begin
      out_cnt++;
      check("tx_err", 32'(to_uart_error), 0);
      if (exp_q.size() == 0) check("unexp_out", 1, 0);
      else check("tx_dat", 32'(to_uart_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_reset_n   = 1'b0;
    from_uart_data  = 8'h00;
    from_uart_valid = 1'b0;
    from_uart_error = 1'b0;
    to_uart_ready   = 1'b0;

    // Reset state.
    repeat (3) step();
    check("rst_rdy",  32'(from_uart_ready), 0);
    check("rst_vld",  32'(to_uart_valid), 0);
    check("rst_dat",  32'(to_uart_data), 0);
    check("rst_err",  32'(err_count), 0);
    check("rst_line", 32'(line_count), 0);
    reset_reset_n = 1'b1;
    #1;
    check("rel_rdy", 32'(from_uart_ready), 1);
    step();
    check("post_vld",  32'(to_uart_valid), 0);
    check("post_dat",  32'(to_uart_data), 0);
    check("post_line", 32'(line_count), 0);

    // "hi\r" with output ready held high; first byte valid right after the DRAIN edge.
    to_uart_ready = 1'b1;
    send_byte(8'h68, 1'b0);
    send_byte(8'h69, 1'b0);
    send_byte(8'h0D, 1'b0);
    check("drain_lat", 32'(to_uart_valid), 1);
    check("drain_rdy", 32'(from_uart_ready), 0);
    wait_idle();
    check("line1", 32'(line_count), 1);

    // 16 bytes without terminator: FIFO full triggers DRAIN.
    to_uart_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0);
    check("full_rdy", 32'(from_uart_ready), 0);
    check("full_vld", 32'(to_uart_valid), 1);
    to_uart_ready = 1'b1;
    wait_idle();
    check("line2", 32'(line_count), 2);

    // Error beat carrying the terminator: dropped, no DRAIN.
    send_byte(8'h61, 1'b0);
    send_byte(8'h0D, 1'b1);
    repeat (3) step();
    check("errterm_vld", 32'(to_uart_valid), 0);
    check("errterm_rdy", 32'(from_uart_ready), 1);
    check("err1", 32'(err_count), 1);
    send_byte(8'h0D, 1'b0);
    wait_idle();
    check("line3", 32'(line_count), 3);

    // Output stalls 1-0-0-1 mid-line.
    to_uart_ready = 1'b0;
    send_byte(8'h78, 1'b0);
    send_byte(8'h79, 1'b0);
    send_byte(8'h7A, 1'b0);
    send_byte(8'h0D, 1'b0);
    base = out_cnt;
    to_uart_ready = 1'b1; step();
    to_uart_ready = 1'b0; step();
    to_uart_ready = 1'b0; step();
    to_uart_ready = 1'b1;
    wait_idle();
    check("stall_cnt", 32'(out_cnt - base), 4);
    check("line4", 32'(line_count), 4);

    // Saturating error counter and wrapping line counter.
    for (int i = 0; i < 300; i++) send_byte(8'h55, 1'b1);
    check("err_sat", 32'(err_count), 255);
    for (int i = 0; i < 253; i++) begin
      send_byte(8'h0D, 1'b0);
      wait_idle();
    end
    check("line_wrap", 32'(line_count), 1);

    // Reset after 2 of 5 bytes drained.
    to_uart_ready = 1'b0;
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b0);
    send_byte(8'h64, 1'b0);
    send_byte(8'h0D, 1'b0);
    base = out_cnt;
    to_uart_ready = 1'b1;
    @(posedge clk_clk);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_cnt", 32'(out_cnt - base), 2);
    check("mid_vld", 32'(to_uart_valid), 0);
    check("mid_rdy", 32'(from_uart_ready), 0);
    step();
    check("mid_err",  32'(err_count), 0);
    check("mid_line", 32'(line_count), 0);
    check("mid_dat",  32'(to_uart_data), 0);
    reset_reset_n = 1'b1;
    step();
    check("after_vld", 32'(to_uart_valid), 0);
    check("after_rdy", 32'(from_uart_ready), 1);
    check("after_cnt", 32'(out_cnt - base), 2);
    send_byte(8'h0D, 1'b0);
    wait_idle();
    check("after_line", 32'(line_count), 1);
    check("q_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_line_echo.md
UART_LINE_ECHO -- requirements
Module: uart_line_echo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO byte capacity; power of 2, range 4..256.
REQ-002 SHALL have parameter TERM_CHAR, default 8'h0D, line terminator byte.
REQ-003 SHALL have port clk_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port from_uart_data  input  8  received byte from the UART core.
REQ-006 SHALL have port from_uart_valid  input  1  from_uart_data is valid.
REQ-007 SHALL have port from_uart_error  input  1  framing/parity error flag for the current beat.
REQ-008 SHALL have port from_uart_ready  output  1  block accepts the receive beat this cycle.
REQ-009 SHALL have port to_uart_data  output  8  byte to transmit.
REQ-010 SHALL have port to_uart_valid  output  1  to_uart_data is valid.
REQ-011 SHALL have port to_uart_error  output  1  transmit error flag; tied 0.
REQ-012 SHALL have port to_uart_ready  input  1  UART core accepts the transmit beat.
REQ-013 SHALL have port err_count  output  8  count of dropped error beats, saturating.
REQ-014 SHALL have port line_count  output  8  count of completed echoed lines, wrapping.

Function
REQ-015 SHALL treat both streams as Avalon-ST with ready latency 0: a transfer occurs on a rising edge where valid=1 and ready=1.
REQ-016 SHALL implement a two-state FSM: FILL (accept input) and DRAIN (emit output), plus a DEPTH-entry circular FIFO with wr_ptr, rd_ptr and a count of width log2(DEPTH)+1.
REQ-017 SHALL drive from_uart_ready = reset_reset_n AND state==FILL AND count<DEPTH, and SHALL keep it 0 in DRAIN.
REQ-018 On an accepted beat with from_uart_error=0, SHALL write the byte at wr_ptr, advance wr_ptr modulo DEPTH, and increment count.
REQ-019 On an accepted beat with from_uart_error=1, SHALL discard the byte, leave the FIFO unchanged, and increment err_count, saturating at 255.
REQ-020 SHALL move FILL->DRAIN on the edge where a stored byte equals TERM_CHAR, or where count becomes DEPTH.
REQ-021 An error beat carrying TERM_CHAR SHALL NOT trigger DRAIN.
REQ-022 In DRAIN, SHALL drive to_uart_valid=1 and to_uart_data = FIFO[rd_ptr], holding both stable until to_uart_ready=1.
REQ-023 On each output transfer, SHALL advance rd_ptr modulo DEPTH and decrement count.
REQ-024 On the edge where the last byte transfers (count 1->0), SHALL return to FILL and increment line_count, wrapping 255->0.
REQ-025 SHALL drive to_uart_valid=0 in FILL; push and pop SHALL never occur in the same cycle.
REQ-026 SHALL add no latency beyond one cycle: the first output byte is valid on the cycle after the DRAIN transition.
REQ-027 SHALL drive to_uart_error=0 at all times.

Reset
REQ-028 While reset_reset_n=0 at a rising edge, SHALL set state=FILL, wr_ptr=rd_ptr=0, count=0, err_count=0, line_count=0; FIFO contents need not be cleared.
REQ-029 During reset and on the first cycle after it, SHALL drive to_uart_valid=0, to_uart_data=0, err_count=0 and line_count=0; from_uart_ready SHALL be 0 while reset_reset_n=0.
REQ-030 Reset asserted mid-DRAIN SHALL abandon the pending line with no further output beats.

Configuration
REQ-031 With macro UART_CASE_FLIP_EN defined, to_uart_data SHALL be FIFO[rd_ptr] minus 8'h20 when that byte is in 8'h61..8'h7A, else unchanged; the FIFO SHALL store raw bytes.
REQ-032 Without UART_CASE_FLIP_EN, to_uart_data SHALL equal FIFO[rd_ptr] unmodified.

Verification
REQ-033 Scenario: send "hi",0x0D with ready held high -> output 0x68,0x69,0x0D (0x48,0x49,0x0D with macro); line_count=1.
REQ-034 Scenario: send 16 bytes 0x00..0x0F with no terminator -> from_uart_ready=0 after the 16th; output 0x00..0x0F in order; line_count=1.
REQ-035 Scenario: send "a", then 0x0D with from_uart_error=1 -> no output, err_count=1, state stays FILL.
REQ-036 Scenario: in DRAIN, toggle to_uart_ready 1-0-0-1 -> to_uart_data held stable across stall cycles; no byte lost or duplicated.
REQ-037 Scenario: 300 error beats -> err_count saturates at 255; 257 echoed lines -> line_count=1.
REQ-038 Scenario: assert reset after 2 of 5 bytes are drained -> to_uart_valid=0 from the next cycle, counters=0, state FILL.
